preload_sequencer: RTL and testbench
====================================

Name: preload_sequencer

Overview:
Controller that sequences the pre-load unit through its full operation: weight/activation memory fill, compensation-weight preload, then calculation. It accepts a streamed weight/activation pair per handshake and drives the write address and data for both memories. It then generates the load_mem_done, preload_cweight and cal phase strobes with fixed, parameterised durations. It sits between the host/DMA stream and the pre-load unit of the 8x8 array.

Parameters:
MEM_DEPTH, 64, entries per weight/activation memory (power of 2)
ADDR_W, 6, memory address width = log2(MEM_DEPTH)
W_W, 8, weight width
A_W, 7, activation width
PRELOAD_CYCLES, 3, cycles preload_cweight is held high (1..255)
CAL_CYCLES, 11, cycles cal is held high (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin a sequence; sampled only in IDLE
in_valid  in  1  stream data valid
in_ready  out  1  stream ready
in_weight  in  W_W  streamed weight
in_act  in  A_W  streamed activation
mem_we  out  1  write strobe for the current mem_addr/data
mem_addr  out  ADDR_W  shared weight/activation write address
mem_weight  out  W_W  registered weight to memory
mem_act  out  A_W  registered activation to memory
load_mem_done  out  1  memories full; held through end of sequence
preload_cweight  out  1  compensation-weight preload phase
cal  out  1  calculation phase
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, active-high):
  - rst, asynchronous, active-high; clock clk.
  - State goes to IDLE. All outputs are 0: mem_addr, mem_weight, mem_act, in_ready, and every strobe.
  - Reset mid-sequence abandons the sequence. No done pulse. A new start is required.
- States: IDLE, LOAD, FLUSH, SETTLE, PRELOAD, CAL, FINISH.
- IDLE:
  - start=1 → LOAD. Element counter cleared.
  - in_valid is ignored because in_ready=0.
- LOAD:
  - in_ready=1 (combinational, state==LOAD).
  - Handshake = in_valid & in_ready.
  - Each handshake registers mem_weight/mem_act from the inputs, mem_addr=counter, mem_we=1 for the next cycle, and increments the counter.
  - No handshake: mem_we=0 next cycle. mem_addr/mem_weight/mem_act hold.
  - On the MEM_DEPTH-th handshake (counter==MEM_DEPTH-1) → FLUSH. The counter does not wrap into a second fill.
- FLUSH (1 cycle):
  - The last write is visible (mem_we=1, mem_addr=MEM_DEPTH-1).
  - in_ready=0.
  - → SETTLE.
- SETTLE (1 cycle): mem_we=0, load_mem_done=1 → PRELOAD.
- PRELOAD: preload_cweight=1 for exactly PRELOAD_CYCLES cycles (phase counter) → CAL.
- CAL: cal=1 for exactly CAL_CYCLES cycles → FINISH.
- FINISH (1 cycle): done=1 → IDLE.
- load_mem_done=1 in SETTLE, PRELOAD, CAL and FINISH. It is 0 in IDLE.
- preload_cweight and cal are never high together. There is no idle cycle between PRELOAD and CAL.
- start while busy is ignored. The sequence is not restarted.
- Latency with continuous in_valid, start sampled at edge 0:
  - Handshakes at edges 1..MEM_DEPTH.
  - load_mem_done rises after edge MEM_DEPTH+1.
  - done pulses after edge MEM_DEPTH+2+PRELOAD_CYCLES+CAL_CYCLES.
- Phase counter: 8 bits, reloaded on every state entry.

Optional Feature:
PRELOAD_SEQ_PERF_EN
- Defined:
  - Adds output stall_cnt[15:0]: count of LOAD cycles with in_valid=0.
  - Cleared on reset and on IDLE→LOAD. Saturates at 16'hFFFF.
  - Holds its value after LOAD until the next start.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
- Reset then start at edge 0, in_valid=1 continuously, weights 0..63, activations 63..0, defaults:
  - mem_we high after edges 1..64 with mem_addr 0..63 and data matching.
  - load_mem_done high after edge 65; preload_cweight high after edges 66–68; cal high after edges 69–79.
  - done pulse after edge 80; busy=0 and load_mem_done=0 after edge 81.
- in_valid low for 5 cycles after the 10th handshake: mem_we=0 and mem_addr holds 9 during the stall; the 11th write goes to addr 10; done is delayed by exactly 5 cycles. With PRELOAD_SEQ_PERF_EN, stall_cnt=5.
- start pulsed again during CAL: no change to the cal duration (11 cycles); done fires once; the FSM returns to IDLE.
- rst asserted during LOAD at addr 30 (asynchronous, mid-cycle): all outputs 0 immediately. A following start reloads from addr 0 and completes the full 64-entry fill.
- in_valid=1 in IDLE without start for 20 cycles: in_ready=0, mem_we never asserts, busy stays 0.
- Override PRELOAD_CYCLES=1 and CAL_CYCLES=1: single-cycle preload_cweight immediately followed by single-cycle cal, then done the next cycle.

Source files
------------

// File: rtl/preload_sequencer.sv
// Pre-load unit sequencer: memory fill from a valid/ready stream, then timed preload and cal phases.
// Optional `PRELOAD_SEQ_PERF_EN adds a saturating stall_cnt output (LOAD cycles without in_valid).
module preload_sequencer #(
    parameter int MEM_DEPTH      = 64,
    parameter int ADDR_W         = 6,
    parameter int W_W            = 8,
    parameter int A_W            = 7,
    parameter int PRELOAD_CYCLES = 3,
    parameter int CAL_CYCLES     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_W-1:0]    in_weight,
    input  logic [A_W-1:0]    in_act,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [W_W-1:0]    mem_weight,
    output logic [A_W-1:0]    mem_act,
    output logic              load_mem_done,
    output logic              preload_cweight,
    output logic              cal,
    output logic              busy,
    output logic              done
`ifdef PRELOAD_SEQ_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE, LOAD, FLUSH, SETTLE, PRELOAD, CAL, FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] elem_cnt;
    logic [7:0]        phase_cnt;
    logic              hs;

    assign hs = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n         = state;
        in_ready        = 1'b0;
        load_mem_done   = 1'b0;
        preload_cweight = 1'b0;
        cal             = 1'b0;
        done            = 1'b0;
        busy            = (state != IDLE);
        case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (hs && elem_cnt == LAST_ADDR) state_n = FLUSH;
            end
            FLUSH:   state_n = SETTLE;
            SETTLE: begin
                load_mem_done = 1'b1;
                state_n       = PRELOAD;
            end
            PRELOAD: begin
                load_mem_done   = 1'b1;
                preload_cweight = 1'b1;
                if (phase_cnt == 8'd0) state_n = CAL;
            end
            CAL: begin
                load_mem_done = 1'b1;
                cal           = 1'b1;
                if (phase_cnt == 8'd0) state_n = FINISH;
            end
            FINISH: begin
                load_mem_done = 1'b1;
                done          = 1'b1;
                state_n       = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Phase counter holds remaining cycles minus one; reloaded on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= 8'd0;
        end else if (state_n != state) begin
            case (state_n)
                PRELOAD: phase_cnt <= 8'(PRELOAD_CYCLES - 1);
                CAL:     phase_cnt <= 8'(CAL_CYCLES - 1);
                default: phase_cnt <= 8'd0;
            endcase
        end else if (phase_cnt != 8'd0) begin
            phase_cnt <= phase_cnt - 8'd1;
        end
    end

    // Write port is one cycle behind the handshake; address/data hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_weight <= '0;
            mem_act    <= '0;
        end else begin
            mem_we <= hs;
            if (state == IDLE && start) elem_cnt <= '0;
            if (hs) begin
                mem_addr   <= elem_cnt;
                mem_weight <= in_weight;
                mem_act    <= in_act;
                elem_cnt   <= elem_cnt + 1'b1;
            end
        end
    end

`ifdef PRELOAD_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (state == IDLE && start) begin
            stall_cnt <= 16'd0;
        end else if (state == LOAD && !in_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_preload_sequencer.sv
// Self-checking bench for preload_sequencer: write scoreboard, phase timeline model, checkpoint table.
module tb_preload_sequencer;
    logic       clk = 1'b0;
    logic       rst, start, start_s, in_valid;
    logic [7:0] in_weight;
    logic [6:0] in_act;

    logic       in_ready, mem_we, load_mem_done, preload_cweight, cal, busy, done;
    logic [5:0] mem_addr;
    logic [7:0] mem_weight;
    logic [6:0] mem_act;

    logic       s_in_ready, s_mem_we, s_ldone, s_pre, s_cal, s_busy, s_done;
    logic [5:0] s_mem_addr;
    logic [7:0] s_mem_weight;
    logic [6:0] s_mem_act;
`ifdef PRELOAD_SEQ_PERF_EN
    logic [15:0] stall_cnt, s_stall_cnt;
`endif

    always #5 clk = ~clk;

    preload_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_weight(in_weight), .in_act(in_act), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_weight(mem_weight), .mem_act(mem_act), .load_mem_done(load_mem_done),
        .preload_cweight(preload_cweight), .cal(cal), .busy(busy), .done(done)
`ifdef PRELOAD_SEQ_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    preload_sequencer #(.PRELOAD_CYCLES(1), .CAL_CYCLES(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_weight(in_weight), .in_act(in_act), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_weight(s_mem_weight), .mem_act(s_mem_act), .load_mem_done(s_ldone),
        .preload_cweight(s_pre), .cal(s_cal), .busy(s_busy), .done(s_done)
`ifdef PRELOAD_SEQ_PERF_EN
        , .stall_cnt(s_stall_cnt)
`endif
    );

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] w;
        logic [6:0] a;
    } wr_t;

    typedef struct {
        int e;
        bit we;
        int addr;
        bit ld, pre, cl, dn, bsy;
    } vec_t;

    wr_t  sb[$];
    vec_t tbl[9];

    int n_chk = 0, n_fail = 0;
    int m_mode, m_cnt, m_post, m_stall, rel;
    bit hs_prev;
    logic [5:0] last_addr;
    logic [7:0] last_w;
    logic [6:0] last_a;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t rel=%0d: got %0d expected %0d", name, $time, rel, act, exp);
        end
    endtask

    function automatic logic [3:0] phase(input int p, input int c);
        logic [3:0] r;
        r = 4'b0;
        if (m_mode == 2) begin
            r[3] = (m_post >= 1) && (m_post <= 2 + p + c);
            r[2] = (m_post >= 2) && (m_post <= 1 + p);
            r[1] = (m_post >= 2 + p) && (m_post <= 1 + p + c);
            r[0] = (m_post == 2 + p + c);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_post = 0; m_stall = 0;
        hs_prev = 1'b0;
        last_addr = '0; last_w = '0; last_a = '0;
        sb.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, int'({mem_we, in_ready, load_mem_done, preload_cweight, cal, busy, done}), 0);
        chk({tag, "_data"}, int'({mem_addr, mem_weight, mem_act}), 0);
        chk({tag, "_short"}, int'({s_mem_we, s_in_ready, s_ldone, s_pre, s_cal, s_busy, s_done}), 0);
    endtask

    // One clock: model the edge from the driven inputs, then compare after the edge.
    task automatic step();
        bit hs;
        logic [3:0] e, es;
        wr_t w;
        hs = (m_mode == 1) && in_valid;
        if (hs) sb.push_back({m_cnt[5:0], in_weight, in_act});
        case (m_mode)
            0: if (start) begin m_mode = 1; m_cnt = 0; m_stall = 0; end
            1: begin
                if (!in_valid) m_stall++;
                if (hs) begin
                    m_cnt++;
                    if (m_cnt == 64) begin m_mode = 2; m_post = 0; end
                end
            end
            default: begin m_post++; if (m_post == 17) m_mode = 0; end
        endcase
        @(posedge clk); #1;
        rel++;
        e  = phase(3, 11);
        es = phase(1, 1);
        chk("in_ready", int'(in_ready), int'(m_mode == 1));
        chk("busy", int'(busy), int'(m_mode != 0));
        chk("strobes", int'({load_mem_done, preload_cweight, cal, done}), int'(e));
        chk("s_busy", int'(s_busy), int'(m_mode == 1 || (m_mode == 2 && m_post <= 4)));
        chk("s_strobes", int'({s_ldone, s_pre, s_cal, s_done}), int'(es));
        chk("mem_we", int'(mem_we), int'(hs));
        if (mem_we) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                w = sb.pop_front();
                chk("wr_addr", int'(mem_addr), int'(w.addr));
                chk("wr_data", int'({mem_weight, mem_act}), int'({w.w, w.a}));
                last_addr = w.addr; last_w = w.w; last_a = w.a;
            end
        end else begin
            chk("hold", int'({mem_addr, mem_weight, mem_act}), int'({last_addr, last_w, last_a}));
        end
        hs_prev = hs;
    endtask

    task automatic drive_data();
        in_weight = m_cnt[7:0];
        in_act    = 7'(63 - m_cnt);
    endtask

    // Full sequence from IDLE; optional stall after stall_at handshakes and a stray start during CAL.
    task automatic run_seq(input int stall_at, input int stall_len, input int restart_post,
                           input bit use_tbl, output int done_rel);
        int guard, ndone, stalled;
        guard = 0; ndone = 0; stalled = 0; done_rel = -1;
        rel = -1;
        start = 1'b1; start_s = 1'b1; in_valid = 1'b1; drive_data();
        step();
        start = 1'b0; start_s = 1'b0;
        while (m_mode != 0 && guard < 300) begin
            guard++;
            if (m_cnt == stall_at && stalled < stall_len) begin
                in_valid = 1'b0; stalled++;
            end else begin
                in_valid = 1'b1;
            end
            drive_data();
            start = (m_mode == 2 && m_post == restart_post);
            step();
            start = 1'b0;
            if (done) begin ndone++; done_rel = rel; end
            if (use_tbl)
                foreach (tbl[i])
                    if (tbl[i].e == rel) begin
                        chk("tbl_we", int'(mem_we), int'(tbl[i].we));
                        chk("tbl_addr", int'(mem_addr), tbl[i].addr);
                        chk("tbl_phase", int'({load_mem_done, preload_cweight, cal, done, busy}),
                            int'({tbl[i].ld, tbl[i].pre, tbl[i].cl, tbl[i].dn, tbl[i].bsy}));
                    end
        end
        in_valid = 1'b0;
        chk("seq_timeout", int'(guard < 300), 1);
        chk("done_count", ndone, 1);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int dr;
        tbl[0] = '{1,  1, 0,  0, 0, 0, 0, 1};
        tbl[1] = '{64, 1, 63, 0, 0, 0, 0, 1};
        tbl[2] = '{65, 0, 63, 1, 0, 0, 0, 1};
        tbl[3] = '{66, 0, 63, 1, 1, 0, 0, 1};
        tbl[4] = '{68, 0, 63, 1, 1, 0, 0, 1};
        tbl[5] = '{69, 0, 63, 1, 0, 1, 0, 1};
        tbl[6] = '{79, 0, 63, 1, 0, 1, 0, 1};
        tbl[7] = '{80, 0, 63, 1, 0, 0, 1, 1};
        tbl[8] = '{81, 0, 63, 0, 0, 0, 0, 0};

        rst = 1'b1; start = 1'b0; start_s = 1'b0; in_valid = 1'b0;
        in_weight = '0; in_act = '0;
        model_reset();
        rel = 0;
        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // in_valid in IDLE without start must be ignored
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) step();
        in_valid = 1'b0;

        // Continuous stream with checkpoint table
        run_seq(-1, 0, -1, 1'b1, dr);
        chk("done_edge", dr, 80);
`ifdef PRELOAD_SEQ_PERF_EN
        chk("stall_cnt0", int'(stall_cnt), 0);
`endif
        for (int i = 0; i < 3; i++) step();

        // Five-cycle stall after the 10th handshake
        run_seq(10, 5, -1, 1'b0, dr);
        chk("stall_done_edge", dr, 85);
`ifdef PRELOAD_SEQ_PERF_EN
        chk("stall_cnt5", int'(stall_cnt), 5);
`endif
        step();

        // Stray start in the middle of CAL
        run_seq(-1, 0, 8, 1'b0, dr);
        chk("restart_done_edge", dr, 80);
        for (int i = 0; i < 3; i++) step();

        // Asynchronous reset mid-LOAD once address 30 has been written
        rel = -1;
        start = 1'b1; start_s = 1'b1; in_valid = 1'b1; drive_data();
        step();
        start = 1'b0; start_s = 1'b0;
        for (int i = 0; i < 40 && m_cnt < 31; i++) begin drive_data(); step(); end
        chk("pre_rst_addr", int'(mem_addr), 30);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        model_reset();
        #1 rst = 1'b0;
        in_valid = 1'b0;
        step();
        run_seq(-1, 0, -1, 1'b0, dr);
        chk("post_rst_done_edge", dr, 80);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
